// File: rtl/delta_sigma_pkg.sv
// delta_sigma_pkg: shared widths and defaults for the delta-sigma modulator/decoder pair.
package delta_sigma_pkg;
    localparam int OVF_CNT_BITS   = 8;
    localparam int DEF_OUT_BITS   = 12;
    localparam int DEF_LOG2_DECIM = 6;
    function automatic int cic_width(input int log2_decim);
        return 2 * log2_decim + 1;
    endfunction
endpackage

// File: rtl/delta_sigma_integrator.sv
// delta_sigma_integrator: W-bit ena-gated wrapping accumulator with synchronous reset.
module delta_sigma_integrator #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_ena,
    input  logic [W-1:0] i_inc,
    output logic [W-1:0] o_acc
);
    logic [W-1:0] r_acc;
    always_ff @(posedge clk) begin
        if (rst) r_acc <= '0;
        else if (i_ena) r_acc <= r_acc + i_inc;
    end
    assign o_acc = r_acc;
endmodule

// File: rtl/delta_sigma_decoder.sv
// delta_sigma_decoder: sinc^2 CIC decimator from a 1-bit stream to OUT_BITS samples over valid/ready.
// Optional DS_DECODE_OVF_CNT_EN adds a saturating overrun_count output.
module delta_sigma_decoder
    import delta_sigma_pkg::*;
#(
    parameter int OUT_BITS   = DEF_OUT_BITS,
    parameter int LOG2_DECIM = DEF_LOG2_DECIM
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                in,
    output logic [OUT_BITS-1:0] out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun
`ifdef DS_DECODE_OVF_CNT_EN
    ,output logic [OVF_CNT_BITS-1:0] overrun_count
`endif
);
    localparam int W = cic_width(LOG2_DECIM);
    localparam logic [W-1:0] R_SQ = {1'b1, {(2*LOG2_DECIM){1'b0}}};

    logic [LOG2_DECIM-1:0]   r_cnt;
    logic                    r_tick;
    logic [1:0]              r_warm;
    logic [W-1:0]            r_d1, r_d2;
    logic [OUT_BITS-1:0]     r_out;
    logic                    r_valid, r_overrun;
    logic [W-1:0]            w_in, w_i1, w_i1_next, w_i2, w_c1, w_c2;
    logic [2*LOG2_DECIM-1:0] w_s;
    logic                    w_load, w_ovf;

    assign w_in      = {{(W-1){1'b0}}, in};
    assign w_i1_next = w_i1 + w_in;

    delta_sigma_integrator #(.W(W)) u_int1 (
        .clk(clk), .rst(rst), .i_ena(ena), .i_inc(w_in), .o_acc(w_i1)
    );
    delta_sigma_integrator #(.W(W)) u_int2 (
        .clk(clk), .rst(rst), .i_ena(ena), .i_inc(w_i1_next), .o_acc(w_i2)
    );

    // Full-scale R^2 does not fit 2*LOG2_DECIM bits, so it clips to all ones.
    always_comb begin
        w_c1   = w_i2 - r_d1;
        w_c2   = w_c1 - r_d2;
        w_s    = (w_c2 == R_SQ) ? '1 : w_c2[2*LOG2_DECIM-1:0];
        w_load = r_tick && (r_warm == 2'd2);
        w_ovf  = w_load && r_valid && !out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_warm    <= '0;
            r_d1      <= '0;
            r_d2      <= '0;
            r_out     <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (ena) r_cnt <= r_cnt + 1'b1;
            r_tick <= ena && (&r_cnt);
            if (r_tick) begin
                r_d1 <= w_i2;
                r_d2 <= w_c1;
                if (r_warm != 2'd2) r_warm <= r_warm + 2'd1;
            end
            if (w_load) r_out <= w_s[2*LOG2_DECIM-1 -: OUT_BITS];
            r_valid   <= w_load || (r_valid && !out_ready);
            r_overrun <= w_ovf;
        end
    end

    assign out       = r_out;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;

`ifdef DS_DECODE_OVF_CNT_EN
    logic [OVF_CNT_BITS-1:0] r_ovf_cnt;
    always_ff @(posedge clk) begin
        if (rst) r_ovf_cnt <= '0;
        else if (w_ovf && !(&r_ovf_cnt)) r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end
    assign overrun_count = r_ovf_cnt;
`endif
endmodule
